// File: rtl/pico_pkg.sv
// Shared types and default sizing for the processor pacing logic.
package pico_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } step_state_t;

    localparam int DB_COUNT_DEF = 500000;
    localparam int CNT_W_DEF    = 16;

endpackage

// File: rtl/debouncer.sv
// Synchronises and debounces an asynchronous pushbutton; emits a one-cycle
// pulse when the accepted level rises.
module debouncer
    import pico_pkg::*;
#(
    parameter int DB_COUNT = DB_COUNT_DEF
) (
    input  logic fastclk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int DB_W = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_COUNT - 1);

    logic            sync_p0;
    logic            sync_p1;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge fastclk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            dout    <= 1'b0;
            rise    <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            rise    <= 1'b0;
            // A new level is accepted only after DB_COUNT consecutive differing samples.
            if (sync_p1 != dout) begin
                if (cnt == CNT_LAST) begin
                    dout <= sync_p1;
                    rise <= sync_p1;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + DB_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/step_controller.sv
// Turns the divider's slow square wave, a run switch and a debounced step
// button into a single-cycle processor clock-enable on fastclk.
module step_controller
    import pico_pkg::*;
#(
    parameter int DB_COUNT = DB_COUNT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             fastclk,
    input  logic             reset,
    input  logic             slow_clk,
    input  logic             run,
    input  logic             step_btn,
    input  logic             halt,
    output logic             cpu_en,
    output logic [CNT_W-1:0] step_count,
    output logic [1:0]       state
);

    step_state_t state_q;
    logic        run_p0;
    logic        run_s;
    logic        slow_prev;
    logic        tick;
    logic        btn_db;
    logic        btn_rise;
    logic        step_req;

    debouncer #(.DB_COUNT(DB_COUNT)) u_step_db (
        .fastclk (fastclk),
        .reset   (reset),
        .din     (step_btn),
        .dout    (btn_db),
        .rise    (btn_rise)
    );

    assign step_req = btn_rise & btn_db;
    assign tick     = slow_clk & ~slow_prev;
    assign state    = state_q;

    always_ff @(posedge fastclk) begin
        if (reset) begin
            run_p0     <= 1'b0;
            run_s      <= 1'b0;
            // Held high so a slow_clk already high out of reset is not a tick.
            slow_prev  <= 1'b1;
            state_q    <= S_IDLE;
            cpu_en     <= 1'b0;
            step_count <= '0;
        end else begin
            run_p0    <= run;
            run_s     <= run_p0;
            slow_prev <= slow_clk;
            cpu_en    <= 1'b0;
            if (cpu_en) begin
                step_count <= step_count + CNT_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (halt)          state_q <= S_HALT;
                    else if (run_s)    state_q <= S_RUN;
                    else if (step_req) cpu_en  <= 1'b1;
                end
                S_RUN: begin
                    if (halt)        state_q <= S_HALT;
                    else if (!run_s) state_q <= S_IDLE;
                    else if (tick)   cpu_en  <= 1'b1;
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_step_controller.sv
// Randomised and directed checks of step_controller against a queue-based
// cycle reference model.
module tb_step_controller;

    localparam int DB = 4;
    localparam int CW = 4;

    logic          fastclk = 1'b0;
    logic          reset = 1'b1;
    logic          slow_clk = 1'b0;
    logic          run = 1'b0;
    logic          step_btn = 1'b0;
    logic          halt = 1'b0;
    logic          cpu_en;
    logic [CW-1:0] step_count;
    logic [1:0]    state;

    int n_checks = 0;
    int n_fail   = 0;

    step_controller #(.DB_COUNT(DB), .CNT_W(CW)) dut (
        .fastclk    (fastclk),
        .reset      (reset),
        .slow_clk   (slow_clk),
        .run        (run),
        .step_btn   (step_btn),
        .halt       (halt),
        .cpu_en     (cpu_en),
        .step_count (step_count),
        .state      (state)
    );

    always #5 fastclk = ~fastclk;

    // Reference model: input histories as queues, debounce as a window test.
    bit run_h[$];
    bit btn_h[$];
    bit bs_q[$];
    bit m_db, m_rise, m_prev, m_en;
    int m_state, m_cnt;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit run_s, btn_s, tick, all_diff, new_rise, new_en;
        int new_state;
        if (reset) begin
            run_h = '{1'b0, 1'b0};
            btn_h = '{1'b0, 1'b0};
            bs_q.delete();
            m_db = 0; m_rise = 0; m_prev = 1; m_en = 0;
            m_state = 0; m_cnt = 0;
            return;
        end
        run_s = run_h[0];
        btn_s = btn_h[0];
        tick  = slow_clk && !m_prev;
        new_en = 0;
        new_state = m_state;
        if (m_state == 2) begin
            new_state = 2;
        end else if (halt) begin
            new_state = 2;
        end else if (m_state == 0) begin
            if (run_s) new_state = 1;
            else if (m_rise) new_en = 1;
        end else begin
            if (!run_s) new_state = 0;
            else if (tick) new_en = 1;
        end
        bs_q.push_back(btn_s);
        if (bs_q.size() > DB) void'(bs_q.pop_front());
        all_diff = (bs_q.size() == DB);
        foreach (bs_q[k]) if (bs_q[k] == m_db) all_diff = 0;
        new_rise = 0;
        if (all_diff) begin
            m_db = btn_s;
            new_rise = btn_s;
            bs_q.delete();
        end
        m_cnt   = (m_cnt + int'(m_en)) % (1 << CW);
        m_en    = new_en;
        m_state = new_state;
        m_rise  = new_rise;
        m_prev  = slow_clk;
        void'(run_h.pop_front()); run_h.push_back(run);
        void'(btn_h.pop_front()); btn_h.push_back(step_btn);
    endtask

    task automatic cycle();
        @(posedge fastclk);
        model_step();
        #1;
        check_val("cpu_en", int'(cpu_en), int'(m_en));
        check_val("step_count", int'(step_count), m_cnt);
        check_val("state", int'(state), m_state);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    initial begin
        bit bounce[8];
        bounce = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        repeat (3) cycle();
        reset = 1'b0;
        check_val("rst_cpu_en", int'(cpu_en), 0);
        check_val("rst_count", int'(step_count), 0);
        check_val("rst_state", int'(state), 0);

        // Free-run, slow_clk toggling every 8 cycles
        run = 1'b1;
        for (int i = 0; i < 70; i++) begin
            slow_clk = ((i / 8) % 2) == 1;
            cycle();
        end

        // Bouncy press then bouncy release while paused
        run = 1'b0; slow_clk = 1'b0;
        do_reset();
        repeat (3) cycle();
        for (int i = 0; i < 4; i++) begin step_btn = bounce[i]; cycle(); end
        step_btn = 1'b1;
        repeat (10) cycle();
        check_val("step_once", int'(step_count), 1);
        for (int i = 4; i < 8; i++) begin step_btn = bounce[i]; cycle(); end
        step_btn = 1'b0;
        repeat (12) cycle();
        check_val("release_no_pulse", int'(step_count), 1);

        // run_s falls on the same cycle as a tick
        do_reset();
        run = 1'b1;
        repeat (6) cycle();
        run = 1'b0;
        repeat (2) cycle();
        slow_clk = 1'b1;
        cycle();
        check_val("runfall_state", int'(state), 0);
        cycle();
        check_val("runfall_en", int'(cpu_en), 0);
        check_val("runfall_count", int'(step_count), 0);
        slow_clk = 1'b0;

        // halt coincident with a tick, then everything else is ignored
        do_reset();
        run = 1'b1;
        repeat (6) cycle();
        halt = 1'b1; slow_clk = 1'b1;
        cycle();
        halt = 1'b0;
        check_val("halt_state", int'(state), 2);
        for (int i = 0; i < 60; i++) begin
            slow_clk = ((i / 3) % 2) == 0;
            step_btn = ((i / 12) % 2) == 1;
            run      = ((i / 20) % 2) == 0;
            cycle();
        end
        check_val("halt_hold_state", int'(state), 2);
        check_val("halt_hold_count", int'(step_count), 0);

        // Reset held with slow_clk high; no tick until the next rise
        run = 1'b1; step_btn = 1'b0; slow_clk = 1'b1;
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        repeat (10) cycle();
        check_val("hi_after_reset", int'(step_count), 0);
        for (int i = 0; i < 24; i++) begin
            slow_clk = ((i / 4) % 2) == 1;
            cycle();
        end

        // Counter wrap: 17 ticks in S_RUN
        slow_clk = 1'b0;
        do_reset();
        repeat (4) cycle();
        for (int i = 0; i < 17; i++) begin
            slow_clk = 1'b1; repeat (2) cycle();
            slow_clk = 1'b0; repeat (2) cycle();
        end
        repeat (3) cycle();
        check_val("wrap_count", int'(step_count), 1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(199) == 0);
            halt  = ($urandom_range(149) == 0);
            if ($urandom_range(29) == 0) run = ~run;
            if ($urandom_range(7) == 0) step_btn = ~step_btn;
            if ($urandom_range(4) == 0) slow_clk = ~slow_clk;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/step_controller.md
Name: step_controller

Overview:
- Execution-pacing stage directly downstream of the clock divider.
- Consumes the divider's slow square wave on the fast board clock and converts it to a single-cycle processor clock-enable.
- Adds a debounced single-step button, a run/pause switch and a halt input from the processor.
- Keeps the whole processor on one clock (fastclk), with no derived clock nets.

Parameters:
- DB_COUNT, 500000: consecutive stable fastclk cycles required to accept a new step_btn level (tests use 4).
- CNT_W, 16: width of the step counter.

Ports:
- fastclk  in  1  board clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- slow_clk  in  1  divider output (count MSB), already in the fastclk domain; not resynchronised.
- run  in  1  run/pause switch, asynchronous; 1 = free-run.
- step_btn  in  1  single-step pushbutton, asynchronous, active-high, bouncy.
- halt  in  1  processor halt request, synchronous to fastclk.
- cpu_en  out  1  one-cycle clock-enable to processor registers.
- step_count  out  CNT_W  number of cpu_en pulses issued.
- state  out  2  current FSM state encoding, for LEDs.

Behaviour:
- One clock (fastclk). Reset is synchronous and active-high.
- Reset values:
  - cpu_en = 0, step_count = 0, state = S_IDLE.
  - Synchroniser flops = 0, debounced button = 0, debounce counter = 0.
  - slow_clk history flop = 1. A high slow_clk right after reset therefore produces no tick.
- Synchronisers: run and step_btn each pass through 2 flops (run_s, btn_s); 2-cycle latency.
- Debounce:
  - If btn_s != btn_db, the counter increments; otherwise it clears.
  - When the counter reaches DB_COUNT-1 while still differing, btn_db <= btn_s and the counter clears.
  - Any glitch back to btn_db restarts the count.
  - step_req = 1-cycle pulse on btn_db rising edge only; release generates nothing.
- Tick: tick = slow_clk & ~slow_prev; slow_prev <= slow_clk every cycle. Exactly one tick per slow_clk period.
- FSM (state enc: S_IDLE=0, S_RUN=1, S_HALT=2; 3 is unused and recovers to S_IDLE next cycle):
  - S_IDLE:
    - halt -> S_HALT, no pulse.
    - else run_s -> S_RUN, no pulse this cycle.
    - else step_req -> cpu_en = 1 next cycle, stay S_IDLE.
    - tick ignored.
  - S_RUN:
    - halt -> S_HALT, no pulse.
    - else !run_s -> S_IDLE, no pulse even if tick coincides.
    - else tick -> cpu_en = 1 next cycle.
    - step_req ignored and not queued.
  - S_HALT: cpu_en held 0; run, step and tick ignored; exit only via reset.
- Priority: reset > halt > run change > tick/step_req.
- cpu_en: registered, high for exactly 1 fastclk cycle per accepted event; latency 1 cycle after the tick/step_req cycle.
- step_count increments in the same cycle cpu_en is high (value visible the following cycle). Wraps 2^CNT_W-1 -> 0 without flag.
- Reset mid-operation:
  - Asserting reset on the cycle after an accepted event forces cpu_en = 0 that cycle; the pulse is lost.
  - A pending debounce is discarded.

Decomposition:
- Shared package pico_pkg:
  - step_state_t enum {S_IDLE, S_RUN, S_HALT} with 2-bit encoding.
  - Default-parameter constants.
- Sub-module debouncer:
  - Parameter DB_COUNT.
  - Ports fastclk, reset, din (async), dout (debounced level), rise (1-cycle pulse).
  - Contains its own 2-flop synchroniser.
  - Instantiated once for step_btn; reusable for future buttons.
- run synchroniser and tick detector stay inline.

Test Plan:
- Reset then run = 1, slow_clk toggling every 8 cycles -> first cpu_en 1 cycle after first slow_clk rise seen in S_RUN; thereafter one pulse per 16 cycles; step_count = 3 after 3 rises.
- DB_COUNT = 4, run = 0:
  - step_btn bounce 1,0,1,0 each 1 cycle, then held 1 for 10 cycles -> exactly one cpu_en, and step_count = 1.
  - Release with bounce -> no further pulse.
- run = 1 with tick on the same cycle run_s falls -> state = S_IDLE, no cpu_en, step_count unchanged.
- halt asserted in the same cycle as a tick in S_RUN -> state = 2, no cpu_en; further ticks, step presses and run toggles -> cpu_en stays 0.
- Synchronous reset asserted with slow_clk = 1 and held 3 cycles, then released with slow_clk still 1 -> no cpu_en until the next 0->1 transition.
- CNT_W = 4 with 17 ticks in S_RUN -> step_count sequence wraps 15 -> 0 and ends at 1.
